// File: rtl/multicycle_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit_pkg
// Shared definitions for the multi-cycle MIPS control unit:
//   - opcode values of every decoded instruction
//   - FSM state encodings (3-bit, also exported on the debug 'state' port)
//   - PcSrc / RegDst selector codes
//   - instruction-class bundle produced by the opcode decoder
// ---------------------------------------------------------------------------
package multicycle_control_unit_pkg;

    // Opcodes (6-bit instruction field)
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_SUBI = 6'b000011;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLTI = 6'b011011;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_BNE  = 6'b110001;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // FSM states; the encoding is visible on the debug port so it is fixed
    typedef enum logic [2:0] {
        ST_IF     = 3'b000,
        ST_ID     = 3'b001,
        ST_EXE_LS = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB_LD  = 3'b100,
        ST_EXE_BR = 3'b101,
        ST_EXE_AL = 3'b110,
        ST_WB_AL  = 3'b111
    } state_t;

    // PC source select
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_REG    = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    // Register-file destination select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // One-hot instruction class; exactly one bit is set for any opcode
    typedef struct packed {
        logic isAlu;
        logic isLw;
        logic isSw;
        logic isBranch;
        logic isJump;
        logic isJr;
        logic isJal;
        logic isHalt;
        logic isIllegal;
    } instClass_t;

endpackage

// File: rtl/mcu_op_decode.sv
// ---------------------------------------------------------------------------
// mcu_op_decode
// Purely combinational opcode decoder for the multi-cycle control unit.
// Produces a one-hot instruction class (used by the FSM for sequencing) and
// the level datapath decodes that stay valid while the opcode is stable.
// Ports:
//   op        in   opcode from the IR
//   instClass out  one-hot instruction class
//   isBeq/isBne out  branch flavour, used to qualify the zero flag
//   aluSrcA, aluSrcB, extSel, dbDataSrc, wrRegDSrc, regDst, aluOp
//             out  level datapath selects
// When HAS_LINK is 0, jr and jal fall into the illegal class.
// ---------------------------------------------------------------------------
module mcu_op_decode
    import multicycle_control_unit_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter bit HAS_LINK = 1'b1
) (
    input  logic [OP_W-1:0] op,
    output instClass_t      instClass,
    output logic            isBeq,
    output logic            isBne,
    output logic            aluSrcA,
    output logic            aluSrcB,
    output logic            extSel,
    output logic            dbDataSrc,
    output logic            wrRegDSrc,
    output logic [1:0]      regDst,
    output logic [2:0]      aluOp
);

    // ALUOp bit meanings: [0] subtract/compare/or-family, [1] shift/or-family,
    // [2] and/set-less-than. Each opcode sets the combination it needs.
    always_comb begin
        instClass = '0;
        isBeq     = 1'b0;
        isBne     = 1'b0;
        aluSrcA   = 1'b0;
        aluSrcB   = 1'b0;
        extSel    = 1'b0;
        dbDataSrc = 1'b0;
        wrRegDSrc = 1'b0;
        regDst    = REGDST_RT;
        aluOp     = 3'b000;
        case (op)
            OP_W'(OP_ADD): begin
                instClass.isAlu = 1'b1;
                regDst          = REGDST_RD;
            end
            OP_W'(OP_ADDI): begin
                instClass.isAlu = 1'b1;
                aluSrcB         = 1'b1;
                extSel          = 1'b1;
            end
            OP_W'(OP_SUB): begin
                instClass.isAlu = 1'b1;
                regDst          = REGDST_RD;
                aluOp           = 3'b001;
            end
            OP_W'(OP_SUBI): begin
                instClass.isAlu = 1'b1;
                aluSrcB         = 1'b1;
                extSel          = 1'b1;
                aluOp           = 3'b001;
            end
            OP_W'(OP_ORI): begin
                instClass.isAlu = 1'b1;
                aluSrcB         = 1'b1;
                aluOp           = 3'b011;
            end
            OP_W'(OP_AND): begin
                instClass.isAlu = 1'b1;
                regDst          = REGDST_RD;
                aluOp           = 3'b100;
            end
            OP_W'(OP_OR): begin
                instClass.isAlu = 1'b1;
                regDst          = REGDST_RD;
                aluOp           = 3'b011;
            end
            OP_W'(OP_SLL): begin
                instClass.isAlu = 1'b1;
                regDst          = REGDST_RD;
                aluSrcA         = 1'b1;
                aluOp           = 3'b010;
            end
            OP_W'(OP_SLTI): begin
                instClass.isAlu = 1'b1;
                aluSrcB         = 1'b1;
                extSel          = 1'b1;
                aluOp           = 3'b101;
            end
            OP_W'(OP_SW): begin
                instClass.isSw = 1'b1;
                aluSrcB        = 1'b1;
                extSel         = 1'b1;
            end
            OP_W'(OP_LW): begin
                instClass.isLw = 1'b1;
                aluSrcB        = 1'b1;
                extSel         = 1'b1;
                dbDataSrc      = 1'b1;
            end
            OP_W'(OP_BEQ): begin
                instClass.isBranch = 1'b1;
                isBeq              = 1'b1;
                extSel             = 1'b1;
                aluOp              = 3'b001;
            end
            OP_W'(OP_BNE): begin
                instClass.isBranch = 1'b1;
                isBne              = 1'b1;
                extSel             = 1'b1;
                aluOp              = 3'b001;
            end
            OP_W'(OP_J): begin
                instClass.isJump = 1'b1;
            end
            OP_W'(OP_JR): begin
                if (HAS_LINK) begin
                    instClass.isJr = 1'b1;
                end else begin
                    instClass.isIllegal = 1'b1;
                end
            end
            OP_W'(OP_JAL): begin
                if (HAS_LINK) begin
                    instClass.isJal = 1'b1;
                    regDst          = REGDST_RA;
                    wrRegDSrc       = 1'b1;
                end else begin
                    instClass.isIllegal = 1'b1;
                end
            end
            OP_W'(OP_HALT): begin
                instClass.isHalt = 1'b1;
            end
            default: begin
                instClass.isIllegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// FSM controller for the multi-cycle MIPS datapath. Walks each instruction
// through IF/ID/EXE/MEM/WB and raises the per-state datapath strobes.
// Ports:
//   CLK, Reset (async, active low)
//   op, zero                     opcode from IR, ALU zero flag
//   PCWre, IRWre, RegWre, mRD, mWR   write/read strobes (forced 0 in reset)
//   InsMemRw                     tied 1
//   ALUSrcA, ALUSrcB, ExtSel, RegDst, WrRegDSrc, DBDataSrc, ALUOp
//                                level decodes of op
//   PcSrc                        PC source select
//   state, halted, illegal_op    debug/status
// ---------------------------------------------------------------------------
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int ALUOP_W  = 3,
    parameter bit HAS_LINK = 1'b1
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    output logic               PCWre,
    output logic               IRWre,
    output logic               InsMemRw,
    output logic               RegWre,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic               ExtSel,
    output logic [1:0]         RegDst,
    output logic               WrRegDSrc,
    output logic               DBDataSrc,
    output logic               mRD,
    output logic               mWR,
    output logic [1:0]         PcSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         state,
    output logic               halted,
    output logic               illegal_op
);

    state_t     stateReg;
    state_t     stateNext;
    logic       haltedReg;
    logic       haltedNext;
    instClass_t instClass;
    logic       isBeq;
    logic       isBne;
    logic [2:0] aluOpRaw;
    logic       pcWreRaw;
    logic       irWreRaw;
    logic       regWreRaw;
    logic       mRdRaw;
    logic       mWrRaw;
    logic       illegalRaw;

    mcu_op_decode #(
        .OP_W     (OP_W),
        .HAS_LINK (HAS_LINK)
    ) opDecode (
        .op        (op),
        .instClass (instClass),
        .isBeq     (isBeq),
        .isBne     (isBne),
        .aluSrcA   (ALUSrcA),
        .aluSrcB   (ALUSrcB),
        .extSel    (ExtSel),
        .dbDataSrc (DBDataSrc),
        .wrRegDSrc (WrRegDSrc),
        .regDst    (RegDst),
        .aluOp     (aluOpRaw)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            stateReg  <= ST_IF;
            haltedReg <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            haltedReg <= haltedNext;
        end
    end

    // Halt is a sticky flag layered on top of ID: once set, the state
    // register freezes at ID until reset.
    always_comb begin
        stateNext  = stateReg;
        haltedNext = haltedReg;
        if (!haltedReg) begin
            case (stateReg)
                ST_IF: stateNext = ST_ID;
                ST_ID: begin
                    if (instClass.isHalt) begin
                        haltedNext = 1'b1;
                        stateNext  = ST_ID;
                    end else if (instClass.isBranch) begin
                        stateNext = ST_EXE_BR;
                    end else if (instClass.isLw || instClass.isSw) begin
                        stateNext = ST_EXE_LS;
                    end else if (instClass.isAlu) begin
                        stateNext = ST_EXE_AL;
                    end else begin
                        stateNext = ST_IF;
                    end
                end
                ST_EXE_LS: stateNext = ST_MEM;
                ST_MEM:    stateNext = instClass.isLw ? ST_WB_LD : ST_IF;
                ST_WB_LD:  stateNext = ST_IF;
                ST_EXE_BR: stateNext = ST_IF;
                ST_EXE_AL: stateNext = ST_WB_AL;
                ST_WB_AL:  stateNext = ST_IF;
                default:   stateNext = ST_IF;
            endcase
        end
    end

    // PCWre marks the final state of every instruction, so the PC moves on
    // the same edge that returns the FSM to IF.
    always_comb begin
        pcWreRaw   = 1'b0;
        irWreRaw   = 1'b0;
        regWreRaw  = 1'b0;
        mRdRaw     = 1'b0;
        mWrRaw     = 1'b0;
        illegalRaw = 1'b0;
        PcSrc      = PCSRC_SEQ;
        if (!haltedReg) begin
            case (stateReg)
                ST_IF: irWreRaw = 1'b1;
                ST_ID: begin
                    if (instClass.isJump || instClass.isJr || instClass.isJal ||
                        instClass.isIllegal) begin
                        pcWreRaw = 1'b1;
                    end
                    if (instClass.isJal) begin
                        regWreRaw = 1'b1;
                    end
                    if (instClass.isJr) begin
                        PcSrc = PCSRC_REG;
                    end else if (instClass.isJump || instClass.isJal) begin
                        PcSrc = PCSRC_JUMP;
                    end
                    illegalRaw = instClass.isIllegal;
                end
                ST_EXE_BR: begin
                    pcWreRaw = 1'b1;
                    if ((isBeq && zero) || (isBne && !zero)) begin
                        PcSrc = PCSRC_BRANCH;
                    end
                end
                ST_MEM: begin
                    mRdRaw = instClass.isLw;
                    mWrRaw = instClass.isSw;
                    if (instClass.isSw) begin
                        pcWreRaw = 1'b1;
                    end
                end
                ST_WB_LD, ST_WB_AL: begin
                    pcWreRaw  = 1'b1;
                    regWreRaw = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Strobes are gated directly by Reset so they drop the instant reset
    // asserts, without waiting for the state register to settle.
    assign PCWre      = pcWreRaw   & Reset;
    assign IRWre      = irWreRaw   & Reset;
    assign RegWre     = regWreRaw  & Reset;
    assign mRD        = mRdRaw     & Reset;
    assign mWR        = mWrRaw     & Reset;
    assign illegal_op = illegalRaw & Reset;
    assign InsMemRw   = 1'b1;
    assign ALUOp      = ALUOP_W'(aluOpRaw);
    assign state      = stateReg;
    assign halted     = haltedReg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
// Self-checking bench: one DUT with jal/jr enabled and one without, driven
// in lockstep from the same opcode/zero inputs.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_SUBI = 6'b000011;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b011001;
    localparam logic [5:0] OP_SLTI = 6'b011011;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_BNE  = 6'b110001;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum int {C_ALU, C_LW, C_SW, C_BR, C_J, C_JR, C_JAL, C_HALT, C_ILL} cls_t;

    typedef struct packed {
        logic [2:0] state;
        logic       pcWre;
        logic       irWre;
        logic       regWre;
        logic       mRd;
        logic       mWr;
        logic [1:0] pcSrc;
        logic       halted;
        logic       illegalOp;
        logic       insMemRw;
        logic       aluSrcA;
        logic       aluSrcB;
        logic       extSel;
        logic [1:0] regDst;
        logic       wrRegDSrc;
        logic       dbDataSrc;
        logic [2:0] aluOp;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         lat;
        int         pcSrc;
        int         regW;
        int         rd;
        int         wr;
        int         ill;
        int         illN;
        int         regWN;
    } vec_t;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] op;
    logic       zero;

    logic       PCWreL, IRWreL, InsMemRwL, RegWreL, ALUSrcAL, ALUSrcBL, ExtSelL;
    logic       WrRegDSrcL, DBDataSrcL, mRDL, mWRL, haltedL, illegalL;
    logic [1:0] RegDstL, PcSrcL;
    logic [2:0] ALUOpL, stateL;
    logic       PCWreN, IRWreN, InsMemRwN, RegWreN, ALUSrcAN, ALUSrcBN, ExtSelN;
    logic       WrRegDSrcN, DBDataSrcN, mRDN, mWRN, haltedN, illegalN;
    logic [1:0] RegDstN, PcSrcN;
    logic [2:0] ALUOpN, stateN;

    obs_t obsL;
    obs_t obsN;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    multicycle_control_unit #(.OP_W(6), .ALUOP_W(3), .HAS_LINK(1'b1)) dutLink (
        .CLK(CLK), .Reset(Reset), .op(op), .zero(zero),
        .PCWre(PCWreL), .IRWre(IRWreL), .InsMemRw(InsMemRwL), .RegWre(RegWreL),
        .ALUSrcA(ALUSrcAL), .ALUSrcB(ALUSrcBL), .ExtSel(ExtSelL), .RegDst(RegDstL),
        .WrRegDSrc(WrRegDSrcL), .DBDataSrc(DBDataSrcL), .mRD(mRDL), .mWR(mWRL),
        .PcSrc(PcSrcL), .ALUOp(ALUOpL), .state(stateL), .halted(haltedL),
        .illegal_op(illegalL)
    );

    multicycle_control_unit #(.OP_W(6), .ALUOP_W(3), .HAS_LINK(1'b0)) dutNoLink (
        .CLK(CLK), .Reset(Reset), .op(op), .zero(zero),
        .PCWre(PCWreN), .IRWre(IRWreN), .InsMemRw(InsMemRwN), .RegWre(RegWreN),
        .ALUSrcA(ALUSrcAN), .ALUSrcB(ALUSrcBN), .ExtSel(ExtSelN), .RegDst(RegDstN),
        .WrRegDSrc(WrRegDSrcN), .DBDataSrc(DBDataSrcN), .mRD(mRDN), .mWR(mWRN),
        .PcSrc(PcSrcN), .ALUOp(ALUOpN), .state(stateN), .halted(haltedN),
        .illegal_op(illegalN)
    );

    assign obsL = {stateL, PCWreL, IRWreL, RegWreL, mRDL, mWRL, PcSrcL, haltedL, illegalL,
                   InsMemRwL, ALUSrcAL, ALUSrcBL, ExtSelL, RegDstL, WrRegDSrcL, DBDataSrcL,
                   ALUOpL};
    assign obsN = {stateN, PCWreN, IRWreN, RegWreN, mRDN, mWRN, PcSrcN, haltedN, illegalN,
                   InsMemRwN, ALUSrcAN, ALUSrcBN, ExtSelN, RegDstN, WrRegDSrcN, DBDataSrcN,
                   ALUOpN};

    // Reference model: what each instruction class does, step by step.
    function automatic cls_t classify(input logic [5:0] o, input bit link);
        case (o)
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_ORI, OP_AND, OP_OR, OP_SLL, OP_SLTI:
                return C_ALU;
            OP_LW:   return C_LW;
            OP_SW:   return C_SW;
            OP_BEQ, OP_BNE: return C_BR;
            OP_J:    return C_J;
            OP_JR:   return link ? C_JR : C_ILL;
            OP_JAL:  return link ? C_JAL : C_ILL;
            OP_HALT: return C_HALT;
            default: return C_ILL;
        endcase
    endfunction

    function automatic int latencyOf(input cls_t c);
        case (c)
            C_ALU:   return 4;
            C_LW:    return 5;
            C_SW:    return 4;
            C_BR:    return 3;
            C_HALT:  return 100;
            default: return 2;
        endcase
    endfunction

    function automatic obs_t modelObs(input logic [5:0] o, input logic z, input bit link,
                                      input int step);
        obs_t e;
        cls_t c;
        int   last;
        c    = classify(o, link);
        last = latencyOf(c) - 1;
        e    = '0;
        e.insMemRw = 1'b1;
        if (step == 0)      e.state = 3'd0;
        else if (step == 1) e.state = 3'd1;
        else if (c == C_HALT) e.state = 3'd1;
        else if (step == 2) e.state = (c == C_ALU) ? 3'd6 : (c == C_BR) ? 3'd5 : 3'd2;
        else if (step == 3) e.state = (c == C_ALU) ? 3'd7 : 3'd3;
        else                e.state = 3'd4;
        e.irWre     = (step == 0);
        e.pcWre     = (c != C_HALT) && (step == last);
        e.halted    = (c == C_HALT) && (step >= 2);
        e.regWre    = ((c == C_ALU || c == C_LW) && step == last) || (c == C_JAL && step == 1);
        e.mRd       = (c == C_LW) && (step == 3);
        e.mWr       = (c == C_SW) && (step == 3);
        e.illegalOp = (c == C_ILL) && (step == 1);
        if (step == 1 && c == C_JR) e.pcSrc = 2'b10;
        if (step == 1 && (c == C_J || c == C_JAL)) e.pcSrc = 2'b11;
        if (step == 2 && c == C_BR)
            e.pcSrc = (((o == OP_BEQ) && z) || ((o == OP_BNE) && !z)) ? 2'b01 : 2'b00;
        e.aluSrcA   = (o == OP_SLL);
        e.aluSrcB   = o inside {OP_ADDI, OP_SUBI, OP_ORI, OP_SLTI, OP_LW, OP_SW};
        e.extSel    = o inside {OP_ADDI, OP_SUBI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE};
        e.dbDataSrc = (o == OP_LW);
        e.wrRegDSrc = (c == C_JAL);
        if (o inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL}) e.regDst = 2'b01;
        else if (c == C_JAL) e.regDst = 2'b10;
        e.aluOp[0] = o inside {OP_SUB, OP_SUBI, OP_OR, OP_ORI, OP_BEQ, OP_BNE, OP_SLTI};
        e.aluOp[1] = o inside {OP_SLL, OP_OR, OP_ORI};
        e.aluOp[2] = o inside {OP_AND, OP_SLTI};
        return e;
    endfunction

    // Level decodes are only meaningful from ID onward.
    function automatic obs_t careMask(input bit levels);
        obs_t m;
        m = '1;
        if (!levels) begin
            m.aluSrcA   = 1'b0;
            m.aluSrcB   = 1'b0;
            m.extSel    = 1'b0;
            m.regDst    = 2'b00;
            m.wrRegDSrc = 1'b0;
            m.dbDataSrc = 1'b0;
            m.aluOp     = 3'b000;
        end
        return m;
    endfunction

    task automatic applyStimulus(input logic [5:0] o, input logic z);
        op   = o;
        zero = z;
    endtask

    task automatic checkOutput(input string name, input obs_t act, input obs_t exp,
                               input obs_t mask);
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            failures++;
            $display("[TB] FAIL %s op=%b zero=%b actual=%h required=%h", name, op, zero,
                     act & mask, exp & mask);
        end
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Call at a falling edge while both DUTs sit in IF.
    task automatic runModelInstr(input logic [5:0] o, input logic z, input int steps);
        applyStimulus(o, z);
        for (int s = 0; s < steps; s++) begin
            #1;
            checkOutput($sformatf("modelLink_step%0d", s), obsL, modelObs(o, z, 1'b1, s),
                        careMask(s != 0));
            checkOutput($sformatf("modelNoLink_step%0d", s), obsN, modelObs(o, z, 1'b0, s),
                        careMask(s != 0));
            @(negedge CLK);
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t       vecs[14];
        logic [5:0] legal[16];
        logic [5:0] ro;
        int         cycles, regW, rd, wr, ill, illN, regWN, pcW, lastPcSrc;

        vecs[0]  = '{OP_ADD,  1'b0, 4, 0, 1, 0, 0, 0, 0, 1};
        vecs[1]  = '{OP_LW,   1'b0, 5, 0, 1, 1, 0, 0, 0, 1};
        vecs[2]  = '{OP_SW,   1'b0, 4, 0, 0, 0, 1, 0, 0, 0};
        vecs[3]  = '{OP_BEQ,  1'b1, 3, 1, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{OP_BEQ,  1'b0, 3, 0, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{OP_BNE,  1'b0, 3, 1, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{OP_BNE,  1'b1, 3, 0, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{OP_J,    1'b0, 2, 3, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{OP_JR,   1'b0, 2, 2, 0, 0, 0, 0, 1, 0};
        vecs[9]  = '{OP_JAL,  1'b0, 2, 3, 1, 0, 0, 0, 1, 0};
        vecs[10] = '{OP_SLT,  1'b0, 2, 0, 0, 0, 0, 1, 1, 0};
        vecs[11] = '{OP_SLL,  1'b1, 4, 0, 1, 0, 0, 0, 0, 1};
        vecs[12] = '{OP_SLTI, 1'b0, 4, 0, 1, 0, 0, 0, 0, 1};
        vecs[13] = '{OP_OR,   1'b1, 4, 0, 1, 0, 0, 0, 0, 1};

        legal = '{OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_ORI, OP_AND, OP_OR, OP_SLL,
                  OP_SLTI, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_J, OP_JR, OP_JAL};

        // Reset state: strobes held low while Reset is low
        Reset = 1'b0;
        applyStimulus(OP_ADD, 1'b0);
        #1;
        checkVal("resetState", int'(stateL), 0);
        checkVal("resetIRWre", int'(IRWreL), 0);
        checkVal("resetPCWre", int'(PCWreL), 0);
        checkVal("resetHalted", int'(haltedL), 0);
        checkVal("resetInsMemRw", int'(InsMemRwL), 1);
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
        #1;
        checkVal("firstIRWreAfterReset", int'(IRWreL), 1);
        @(negedge CLK);
        checkVal("firstIfLeadsToId", int'(stateL), 1);
        // let the add in flight finish: ID -> EXE_AL -> WB_AL -> IF
        repeat (3) @(negedge CLK);
        checkVal("backToIf", int'(stateL), 0);

        // Table-driven per-instruction signatures
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].z);
            cycles = 0; regW = 0; rd = 0; wr = 0; ill = 0; illN = 0; regWN = 0; pcW = 0;
            lastPcSrc = -1;
            while (1) begin
                #1;
                regW  += int'(RegWreL);
                rd    += int'(mRDL);
                wr    += int'(mWRL);
                ill   += int'(illegalL);
                illN  += int'(illegalN);
                regWN += int'(RegWreN);
                if (PCWreL) begin
                    pcW++;
                    lastPcSrc = int'(PcSrcL);
                end
                cycles++;
                @(negedge CLK);
                if (stateL == 3'd0 || cycles >= 10) break;
            end
            checkVal($sformatf("vec%0d_latency", i), cycles, vecs[i].lat);
            checkVal($sformatf("vec%0d_pcWrites", i), pcW, 1);
            checkVal($sformatf("vec%0d_pcSrc", i), lastPcSrc, vecs[i].pcSrc);
            checkVal($sformatf("vec%0d_regWrites", i), regW, vecs[i].regW);
            checkVal($sformatf("vec%0d_memReads", i), rd, vecs[i].rd);
            checkVal($sformatf("vec%0d_memWrites", i), wr, vecs[i].wr);
            checkVal($sformatf("vec%0d_illegal", i), ill, vecs[i].ill);
            checkVal($sformatf("vec%0d_illegalNoLink", i), illN, vecs[i].illN);
            checkVal($sformatf("vec%0d_regWritesNoLink", i), regWN, vecs[i].regWN);
        end

        // Randomized instruction stream against the model
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                ro = legal[$urandom_range(0, 15)];
            end else begin
                ro = 6'($urandom);
                if (ro == OP_HALT) ro = OP_SLT;
            end
            runModelInstr(ro, 1'($urandom), latencyOf(classify(ro, 1'b1)));
        end

        // Halt is sticky: several cycles parked in ID with PCWre low
        runModelInstr(OP_HALT, 1'b0, 8);
        Reset = 1'b0;
        #1;
        checkVal("haltClearedByReset", int'(haltedL), 0);
        checkVal("haltResetState", int'(stateL), 0);
        @(negedge CLK);
        Reset = 1'b1;
        runModelInstr(OP_ADDI, 1'b0, 4);

        // Reset during lw's MEM cycle kills the read strobe at once
        runModelInstr(OP_LW, 1'b0, 3);
        #1;
        checkVal("midLwMemRead", int'(mRDL), 1);
        Reset = 1'b0;
        #1;
        checkVal("midLwResetMRD", int'(mRDL), 0);
        checkVal("midLwResetState", int'(stateL), 0);
        checkVal("midLwResetRegWre", int'(RegWreL), 0);
        checkVal("midLwResetPCWre", int'(PCWreL), 0);
        @(negedge CLK);
        #1;
        checkVal("heldResetIRWre", int'(IRWreL), 0);
        @(negedge CLK);
        Reset = 1'b1;
        runModelInstr(OP_SW, 1'b0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Finite-state control unit for the multi-cycle MIPS datapath; replaces the single-cycle opcode decoder.
- Sequences each instruction through IF/ID/EXE/MEM/WB states.
- Drives per-state datapath strobes (PC, IR, register file, data memory).
- Adds jal/jr (optional) plus halted and illegal-opcode reporting.

Parameters:
OP_W, 6, opcode width.
ALUOP_W, 3, ALU operation select width.
HAS_LINK, 1, when 1 jal (111010) and jr (111001) are decoded; when 0 they are illegal.

Ports:
CLK  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
op  in  OP_W  opcode from IR output; stable from ID onward
zero  in  1  ALU zero flag, sampled in EXE_BR
PCWre  out  1  PC write enable
IRWre  out  1  IR write enable
InsMemRw  out  1  constant 1 (instruction memory read)
RegWre  out  1  register file write enable
ALUSrcA  out  1  1 = shift amount (sll)
ALUSrcB  out  1  1 = extended immediate
ExtSel  out  1  1 = sign-extend, 0 = zero-extend
RegDst  out  2  00 rt, 01 rd, 10 $31
WrRegDSrc  out  1  0 = ALU/memory result, 1 = PC+4 (jal)
DBDataSrc  out  1  1 = memory read data
mRD  out  1  data memory read
mWR  out  1  data memory write
PcSrc  out  2  00 PC+4, 01 branch target, 10 rs (jr), 11 jump target
ALUOp  out  ALUOP_W  ALU function select
state  out  3  current state (debug)
halted  out  1  1 while in HALT
illegal_op  out  1  one-cycle pulse in ID on an undecoded opcode

Behaviour:
- Opcodes: add 000000, addi 000001, sub 000010, subi 000011, ori 010000, and 010001, or 010010, sll 011000, slti 011011, sw 100110, lw 100111, beq 110000, bne 110001, j 111000, jr 111001, jal 111010, halt 111111.
- Unknown opcodes, including slt 011001, are illegal.
- State encodings: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111.
- HALT is a separate sticky flag with state held at ID; halted=1.
- Transitions:
  - IF -> ID always.
  - ID -> IF for j, jr, jal, and illegal opcodes.
  - ID -> EXE_BR for beq/bne; EXE_BR -> IF.
  - ID -> EXE_LS for lw/sw; EXE_LS -> MEM.
  - MEM -> IF for sw; MEM -> WB_LD for lw; WB_LD -> IF.
  - ID -> EXE_AL for ALU ops (add, addi, sub, subi, ori, and, or, sll, slti); EXE_AL -> WB_AL -> IF.
  - ID with halt sets halted; the FSM stays there until Reset.
- Latency in cycles: j/jr/jal 2, beq/bne 3, sw 4, ALU ops 4, lw 5.
- Strobes are Moore/Mealy on state and op.
  - IRWre=1 only in IF.
  - PCWre=1 in the last state of each instruction: ID for j/jr/jal/illegal, EXE_BR, MEM for sw, WB_AL, WB_LD. So PC updates on the edge that returns to IF.
  - PCWre=0 in HALT.
  - RegWre=1 in WB_AL, WB_LD, and ID for jal.
  - mRD=1 in MEM for lw; mWR=1 in MEM for sw.
- Level decodes hold from ID through the final state of the instruction:
  - ALUSrcA = sll.
  - ALUSrcB = addi | subi | ori | slti | lw | sw.
  - ExtSel = addi | subi | slti | lw | sw | beq | bne.
  - DBDataSrc = lw.
  - RegDst: 01 for add/sub/and/or/sll; 10 for jal; else 00.
  - WrRegDSrc = jal.
  - ALUOp[0] = sub | subi | or | ori | beq | bne | slti.
  - ALUOp[1] = sll | or | ori.
  - ALUOp[2] = and | slti.
  - Higher ALUOp bits (ALUOP_W > 3) are 0.
- PcSrc: 00 by default.
  - 01 in EXE_BR when (beq & zero) | (bne & ~zero).
  - 10 for jr; 11 for j/jal (in ID).
  - Not-taken branch: PcSrc=00 with PCWre=1 (sequential PC).
- Reset:
  - Reset low asynchronously forces state=IF and clears halted.
  - While Reset is low, PCWre, IRWre, RegWre, mRD and mWR are forced 0.
  - First IRWre occurs in the first cycle after Reset deasserts.
  - Reset mid-instruction abandons it; no partial write strobe is issued after assertion.
- illegal_op pulses for exactly one cycle (ID) and is then treated as a nop.
- With HAS_LINK=0, jr/jal behave as illegal.

Decomposition:
- Shared package holds:
  - opcode localparams;
  - state encodings (3-bit);
  - PcSrc and RegDst codes.
- Natural sub-module: mcu_op_decode — combinational opcode -> one-hot instruction class plus level decodes. The FSM lives in the parent.

Test Plan:
1. add (000000) after reset -> states IF,ID,EXE_AL,WB_AL,IF; RegWre=1 only in WB_AL with RegDst=01; PCWre=1 only in WB_AL.
2. lw (100111) -> 5 cycles; mRD=1 in MEM; RegWre=1 and DBDataSrc=1 in WB_LD; ALUSrcB=1, ExtSel=1.
3. beq with zero=1 -> PcSrc=01 and PCWre=1 in EXE_BR; repeat with zero=0 -> PcSrc=00, PCWre=1. bne mirrors both cases.
4. jal (111010), HAS_LINK=1 -> ID: PcSrc=11, RegWre=1, RegDst=10, WrRegDSrc=1, then IF. With HAS_LINK=0: illegal_op=1 for one cycle, no RegWre.
5. halt (111111) -> halted=1, PCWre=0 indefinitely. Reset low mid-lw (in MEM) -> mRD drops 0 immediately; state=IF; halted cleared.
6. Opcode 011001 -> illegal_op pulse in ID, PCWre=1, PcSrc=00, returns to IF after 2 cycles.
